// File: rtl/aftab_booth_multiplier_pkg.sv
// Shared definitions for the AAU Booth multiplier: FSM state codes and
// radix-2 Booth recoding helpers.
package aftab_mul_defs;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] BOOTH_NOP = 2'd0;
  localparam logic [1:0] BOOTH_ADD = 2'd1;
  localparam logic [1:0] BOOTH_SUB = 2'd2;

  // bits = {Q[0], q_1}
  function automatic logic [1:0] booth_sel(input logic [1:0] bits);
    logic [1:0] sel;
    case (bits)
      2'b01:   sel = BOOTH_ADD;
      2'b10:   sel = BOOTH_SUB;
      default: sel = BOOTH_NOP;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/aftab_booth_multiplier_controller.sv
// Sequencing FSM and step counter for the radix-2 Booth multiplier.
//   state   | meaning
//   IDLE    | waiting for startMul; operands loaded on accepted start
//   RUN     | one add/sub + arithmetic shift per cycle, size steps
//   DONE    | product valid, doneMul pulses for this single cycle
module aftab_booth_multiplier_controller
  import aftab_mul_defs::*;
#(
  parameter int unsigned size = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       startMul,
  input  logic [1:0] booth_bits,
  output logic       ldM,
  output logic       ldACC,
  output logic       zeroACC,
  output logic       addSub,
  output logic       shR,
  output logic       ldProd,
  output logic       doneMul,
  output logic       busy
);

  localparam int unsigned CW = $clog2(size + 1);
  localparam logic [CW-1:0] LAST = CW'(size - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel     = booth_sel(booth_bits);
    ldM     = 1'b0;
    ldACC   = 1'b0;
    zeroACC = 1'b0;
    addSub  = 1'b0;
    shR     = 1'b0;
    ldProd  = 1'b0;
    doneMul = 1'b0;
    busy    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (startMul) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          ldM     = 1'b1;
          zeroACC = 1'b1;
        end
      end
      ST_RUN: begin
        busy   = 1'b1;
        shR    = 1'b1;
        ldACC  = (sel != BOOTH_NOP);
        addSub = (sel == BOOTH_SUB);
        cnt_d  = cnt_q + CW'(1);
        // Product is captured from the final step so it is valid during DONE.
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          ldProd  = 1'b1;
        end
      end
      ST_DONE: begin
        doneMul = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/aftab_booth_multiplier_datapath.sv
// Booth datapath: M, ACC (size+1 bits), Q, q_1, add/sub, arithmetic shifter
// and the product register.
module aftab_booth_multiplier_datapath #(
  parameter int unsigned size = 33
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ldM,
  input  logic              ldACC,
  input  logic              zeroACC,
  input  logic              addSub,
  input  logic              shR,
  input  logic              ldProd,
  input  logic [size-1:0]   multiplicand,
  input  logic [size-1:0]   multiplier,
  output logic [1:0]        booth_bits,
  output logic [2*size-1:0] product
);

  logic [size-1:0]   m_q, qr_q;
  logic [size:0]     acc_q;
  logic              q1_q;
  logic [2*size-1:0] prod_q;

  logic [size:0]     m_ext, sum, acc_pre;
  logic [2*size+1:0] shifted;

  // ACC carries an extra bit so that subtracting the most-negative M cannot overflow.
  assign m_ext   = {m_q[size-1], m_q};
  assign sum     = addSub ? (acc_q - m_ext) : (acc_q + m_ext);
  assign acc_pre = ldACC ? sum : acc_q;
  // {ACC, Q, q_1} >>> 1 : the old q_1 falls off, ACC MSB is replicated.
  assign shifted = {acc_pre[size], acc_pre, qr_q};

  assign booth_bits = {qr_q[0], q1_q};
  assign product    = prod_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q    <= '0;
      qr_q   <= '0;
      acc_q  <= '0;
      q1_q   <= 1'b0;
      prod_q <= '0;
    end else begin
      if (ldM) begin
        m_q  <= multiplicand;
        qr_q <= multiplier;
        q1_q <= 1'b0;
      end else if (shR) begin
        qr_q <= shifted[size:1];
        q1_q <= shifted[0];
      end
      if (zeroACC) begin
        acc_q <= '0;
      end else if (shR) begin
        acc_q <= shifted[2*size+1:size+1];
      end
      if (ldProd) begin
        prod_q <= shifted[2*size:1];
      end
    end
  end

endmodule

// File: rtl/aftab_booth_multiplier.sv
// Sequential signed radix-2 Booth multiplier for the AFTAB AAU
// (start/done handshake, full 2*size-bit product).
module aftab_booth_multiplier #(
  parameter int unsigned size = 33
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              startMul,
  input  logic [size-1:0]   multiplicand,
  input  logic [size-1:0]   multiplier,
  output logic              busy,
  output logic              doneMul,
  output logic [2*size-1:0] product
);

  logic       ldM, ldACC, zeroACC, addSub, shR, ldProd;
  logic [1:0] booth_bits;

  aftab_booth_multiplier_controller #(.size(size)) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .startMul   (startMul),
    .booth_bits (booth_bits),
    .ldM        (ldM),
    .ldACC      (ldACC),
    .zeroACC    (zeroACC),
    .addSub     (addSub),
    .shR        (shR),
    .ldProd     (ldProd),
    .doneMul    (doneMul),
    .busy       (busy)
  );

  aftab_booth_multiplier_datapath #(.size(size)) u_dp (
    .clk          (clk),
    .rst          (rst),
    .ldM          (ldM),
    .ldACC        (ldACC),
    .zeroACC      (zeroACC),
    .addSub       (addSub),
    .shR          (shR),
    .ldProd       (ldProd),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .booth_bits   (booth_bits),
    .product      (product)
  );

endmodule

// File: tb/tb_aftab_booth_multiplier.sv
// Scoreboard bench for aftab_booth_multiplier: expected products queued at
// each accepted start, checked when doneMul pulses.
module tb_aftab_booth_multiplier;

  localparam int SIZE = 33;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              startMul = 1'b0;
  logic [SIZE-1:0]   multiplicand = '0;
  logic [SIZE-1:0]   multiplier = '0;
  logic              busy;
  logic              doneMul;
  logic [2*SIZE-1:0] product;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic prev_done = 1'b0;

  logic [2*SIZE-1:0] sb_q[$];
  int                st_q[$];

  aftab_booth_multiplier #(.size(SIZE)) dut (
    .clk          (clk),
    .rst          (rst),
    .startMul     (startMul),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .doneMul      (doneMul),
    .product      (product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [2*SIZE-1:0] obs, input logic [2*SIZE-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [2*SIZE-1:0] model(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    logic signed [2*SIZE-1:0] ax, bx, p;
    ax = {{SIZE{a[SIZE-1]}}, a};
    bx = {{SIZE{b[SIZE-1]}}, b};
    p  = ax * bx;
    return p;
  endfunction

  // Output monitor: every doneMul must match the oldest queued product.
  always @(negedge clk) begin
    if (doneMul) begin
      chk("done_pulse_width", {65'd0, prev_done}, '0);
      if (sb_q.size() == 0) begin
        chk("spurious_done", {65'd0, doneMul}, '0);
      end else begin
        chk("product", product, sb_q.pop_front());
        chk("latency", 66'(cyc - st_q.pop_front()), 66'(SIZE));
      end
    end
    prev_done = doneMul;
  end

  task automatic run_op(input logic [SIZE-1:0] m, input logic [SIZE-1:0] r,
                        input bit jitter, input bit poke);
    logic [63:0] rnd;
    startMul     = 1'b1;
    multiplicand = m;
    multiplier   = r;
    sb_q.push_back(model(m, r));
    @(posedge clk);
    #1;
    st_q.push_back(cyc);
    startMul = 1'b0;
    for (int k = 1; k <= SIZE + 1; k++) begin
      @(negedge clk);
      chk("busy", {65'd0, busy}, {65'd0, (k <= SIZE)});
      if (jitter) begin
        rnd = {$urandom, $urandom};
        multiplicand = rnd[SIZE-1:0];
        rnd = {$urandom, $urandom};
        multiplier = rnd[SIZE-1:0];
      end
      if (poke && k == 10) begin
        startMul     = 1'b1;
        multiplicand = 33'd999;
        multiplier   = 33'd999;
      end
      if (poke && k == 11) startMul = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("sb_drain", 66'(sb_q.size()), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [63:0] rnd;
    logic [SIZE-1:0] ra, rb;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {65'd0, busy}, '0);
    chk("reset_done", {65'd0, doneMul}, '0);
    chk("reset_product", product, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(33'd5, 33'd3, 1'b0, 1'b0);
    chk("hold_5x3", product, 66'd15);
    run_op(-33'sd7, 33'd6, 1'b0, 1'b0);
    chk("hold_m7x6", product, 66'h3_FFFF_FFFF_FFFF_FFD6);
    run_op(33'h1_0000_0000, 33'h1_0000_0000, 1'b0, 1'b0);
    chk("hold_minxmin", product, 66'h1_0000_0000_0000_0000);
    run_op(33'd0, -33'sd1, 1'b0, 1'b0);
    run_op(-33'sd1, -33'sd1, 1'b0, 1'b0);
    chk("hold_m1xm1", product, 66'd1);

    // start while busy is ignored; next op back-to-back
    run_op(33'd123, -33'sd456, 1'b0, 1'b1);
    run_op(33'd77, -33'sd3, 1'b0, 1'b0);

    // reset in the middle of an operation
    startMul     = 1'b1;
    multiplicand = 33'd1000;
    multiplier   = 33'd1000;
    @(posedge clk);
    #1;
    startMul = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", {65'd0, busy}, '0);
    chk("abort_done", {65'd0, doneMul}, '0);
    chk("abort_product", product, '0);
    repeat (40) @(posedge clk);
    #1;

    // reset and start together: reset wins
    rst = 1'b1;
    startMul = 1'b1;
    multiplicand = 33'd9;
    multiplier = 33'd9;
    @(posedge clk);
    #1;
    rst = 1'b0;
    startMul = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", {65'd0, busy}, '0);
    @(posedge clk);
    #1;

    run_op(33'd12, -33'sd12, 1'b0, 1'b0);
    chk("hold_12xm12", product, -66'sd144);
    run_op(33'd100, 33'd200, 1'b1, 1'b0);
    chk("hold_jitter", product, 66'd20000);

    for (int i = 0; i < 4; i++) begin
      rnd = {$urandom, $urandom};
      ra  = rnd[SIZE-1:0];
      rnd = {$urandom, $urandom};
      rb  = rnd[SIZE-1:0];
      run_op(ra, rb, 1'b0, 1'b0);
    end

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
